// File: rtl/ifft8_core.sv
// ifft8_core: iterative 8-point radix-2 DIT inverse FFT, one complex butterfly per clock.
// Define IFFT8_STAGE_SCALE_EN for per-stage >>>1 (normalised IDFT); undefined gives 8x IDFT.
//
// state | meaning
// IDLE  | waiting for start_i; bins loaded bit-reversed on accept
// RUN   | 12 butterflies, 3 stages x 4
// DONE  | x_*_o freshly updated, valid_o pulse, start_i ignored
module ifft8_core #(
    parameter int DATA_W  = 16,
    parameter int TW_FRAC = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [8*DATA_W-1:0] X_R_i,
    input  logic [8*DATA_W-1:0] X_I_i,
    output logic [8*DATA_W-1:0] x_R_o,
    output logic [8*DATA_W-1:0] x_I_o,
    output logic                valid_o,
    output logic                busy_o
);
    localparam int TW_W = TW_FRAC + 2;
    localparam int PW   = DATA_W + TW_W + 1;
    localparam int SW   = DATA_W + 2;
    localparam logic signed [TW_W-1:0] W_ONE  = TW_W'(16384);
    localparam logic signed [TW_W-1:0] W_DIAG = TW_W'(11585);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t state_q, state_d;
    logic [1:0] stage_q, stage_d, bfly_q, bfly_d;
    logic signed [DATA_W-1:0] slot_r_q [8];
    logic signed [DATA_W-1:0] slot_i_q [8];
    logic signed [DATA_W-1:0] slot_r_d [8];
    logic signed [DATA_W-1:0] slot_i_d [8];
    logic signed [DATA_W-1:0] x_r_q [8];
    logic signed [DATA_W-1:0] x_i_q [8];
    logic signed [DATA_W-1:0] x_r_d [8];
    logic signed [DATA_W-1:0] x_i_d [8];

    logic [2:0] top_idx, bot_idx;
    logic [1:0] tw_k;
    logic       last_bfly;
    logic signed [TW_W-1:0]   w_r, w_i;
    logic signed [DATA_W-1:0] a_r, a_i, b_r, b_i;
    logic signed [PW-1:0]     prod_r, prod_i;
    logic signed [SW-1:0]     t_r, t_i, sum_r, sum_i, dif_r, dif_i;
    logic signed [DATA_W-1:0] top_r, top_i, bot_r, bot_i;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v[SW-1:DATA_W-1] == {(SW-DATA_W+1){v[SW-1]}}) r = v[DATA_W-1:0];
        else if (v[SW-1])                                r = {1'b1, {(DATA_W-1){1'b0}}};
        else                                             r = {1'b0, {(DATA_W-1){1'b1}}};
        return r;
    endfunction

    assign last_bfly = (stage_q == 2'd2) && (bfly_q == 2'd3);

    // Slot pair and twiddle index for butterfly bfly_q of stage stage_q
    always_comb begin
        top_idx = 3'd0;
        bot_idx = 3'd0;
        tw_k    = 2'd0;
        case (stage_q)
            2'd0: begin
                top_idx = {bfly_q, 1'b0};
                bot_idx = {bfly_q, 1'b1};
                tw_k    = 2'd0;
            end
            2'd1: begin
                top_idx = {bfly_q[1], 1'b0, bfly_q[0]};
                bot_idx = {bfly_q[1], 1'b1, bfly_q[0]};
                tw_k    = {bfly_q[0], 1'b0};
            end
            default: begin
                top_idx = {1'b0, bfly_q};
                bot_idx = {1'b1, bfly_q};
                tw_k    = bfly_q;
            end
        endcase
    end

    always_comb begin
        w_r = W_ONE;
        w_i = '0;
        case (tw_k)
            2'd0: begin w_r = W_ONE;   w_i = '0;     end
            2'd1: begin w_r = W_DIAG;  w_i = W_DIAG; end
            2'd2: begin w_r = '0;      w_i = W_ONE;  end
            default: begin w_r = -W_DIAG; w_i = W_DIAG; end
        endcase
    end

    always_comb begin
        a_r    = slot_r_q[top_idx];
        a_i    = slot_i_q[top_idx];
        b_r    = slot_r_q[bot_idx];
        b_i    = slot_i_q[bot_idx];
        prod_r = PW'(b_r) * PW'(w_r) - PW'(b_i) * PW'(w_i);
        prod_i = PW'(b_r) * PW'(w_i) + PW'(b_i) * PW'(w_r);
        t_r    = SW'(prod_r >>> TW_FRAC);
        t_i    = SW'(prod_i >>> TW_FRAC);
        sum_r  = SW'(a_r) + t_r;
        sum_i  = SW'(a_i) + t_i;
        dif_r  = SW'(a_r) - t_r;
        dif_i  = SW'(a_i) - t_i;
`ifdef IFFT8_STAGE_SCALE_EN
        top_r  = sat(sum_r >>> 1);
        top_i  = sat(sum_i >>> 1);
        bot_r  = sat(dif_r >>> 1);
        bot_i  = sat(dif_i >>> 1);
`else
        top_r  = sat(sum_r);
        top_i  = sat(sum_i);
        bot_r  = sat(dif_r);
        bot_i  = sat(dif_i);
`endif
    end

    // Outputs take the post-butterfly slots so they are already valid in DONE
    always_comb begin
        slot_r_d = slot_r_q;
        slot_i_d = slot_i_q;
        stage_d  = stage_q;
        bfly_d   = bfly_q;
        if (state_q == IDLE && start_i) begin
            for (int k = 0; k < 8; k++) begin
                slot_r_d[bitrev3(3'(k))] = X_R_i[k*DATA_W +: DATA_W];
                slot_i_d[bitrev3(3'(k))] = X_I_i[k*DATA_W +: DATA_W];
            end
            stage_d = 2'd0;
            bfly_d  = 2'd0;
        end else if (state_q == RUN) begin
            slot_r_d[top_idx] = top_r;
            slot_i_d[top_idx] = top_i;
            slot_r_d[bot_idx] = bot_r;
            slot_i_d[bot_idx] = bot_i;
            if (last_bfly) begin
                stage_d = 2'd0;
                bfly_d  = 2'd0;
            end else begin
                bfly_d = bfly_q + 2'd1;
                if (bfly_q == 2'd3) stage_d = stage_q + 2'd1;
            end
        end
        x_r_d = x_r_q;
        x_i_d = x_i_q;
        if (state_q == RUN && last_bfly) begin
            x_r_d = slot_r_d;
            x_i_d = slot_i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= 2'd0;
            bfly_q  <= 2'd0;
            for (int n = 0; n < 8; n++) begin
                slot_r_q[n] <= '0;
                slot_i_q[n] <= '0;
                x_r_q[n]    <= '0;
                x_i_q[n]    <= '0;
            end
        end else begin
            stage_q  <= stage_d;
            bfly_q   <= bfly_d;
            slot_r_q <= slot_r_d;
            slot_i_q <= slot_i_d;
            x_r_q    <= x_r_d;
            x_i_q    <= x_i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last_bfly) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == RUN);
        valid_o = (state_q == DONE);
    end

    always_comb begin
        x_R_o = '0;
        x_I_o = '0;
        for (int n = 0; n < 8; n++) begin
            x_R_o[n*DATA_W +: DATA_W] = x_r_q[n];
            x_I_o[n*DATA_W +: DATA_W] = x_i_q[n];
        end
    end
endmodule

// File: tb/tb_ifft8_core.sv
// Table-driven bench for ifft8_core; expected values follow IFFT8_STAGE_SCALE_EN if defined.
module tb_ifft8_core;
    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] X_R_i, X_I_i;
    logic [127:0] x_R_o, x_I_o;
    logic         valid_o, busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0][15:0] xr;
        logic [7:0][15:0] xi;
        logic [7:0][15:0] er;
        logic [7:0][15:0] ei;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

`ifdef IFFT8_STAGE_SCALE_EN
    localparam int SC = 1;
`else
    localparam int SC = 8;
`endif

    ifft8_core dut (
        .clk    (clk),
        .rst    (rst),
        .start_i(start_i),
        .X_R_i  (X_R_i),
        .X_I_i  (X_I_i),
        .x_R_o  (x_R_o),
        .x_I_o  (x_I_o),
        .valid_o(valid_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int vi);
        X_R_i   = vecs[vi].xr;
        X_I_i   = vecs[vi].xi;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d_busy_c%0d", vi, c), 128'(busy_o), 128'(c <= 12));
            chk($sformatf("v%0d_valid_c%0d", vi, c), 128'(valid_o), 128'(c == 13));
            if (c == 13) begin
                for (int n = 0; n < 8; n++) begin
                    chk($sformatf("v%0d_xr%0d", vi, n), 128'(x_R_o[n*16 +: 16]), 128'(vecs[vi].er[n]));
                    chk($sformatf("v%0d_xi%0d", vi, n), 128'(x_I_o[n*16 +: 16]), 128'(vecs[vi].ei[n]));
                end
            end
            step();
        end
        chk($sformatf("v%0d_hold_r", vi), x_R_o, vecs[vi].er);
        chk($sformatf("v%0d_hold_i", vi), x_I_o, vecs[vi].ei);
    endtask

    initial begin
        int nvalid;
        for (int i = 0; i < NV; i++) begin
            vecs[i].xr = '0; vecs[i].xi = '0; vecs[i].er = '0; vecs[i].ei = '0;
        end
        // DC real
        vecs[0].xr[0] = 16'(8000);
        for (int n = 0; n < 8; n++) vecs[0].er[n] = 16'(1000 * SC);
        // tone k=1
        vecs[1].xr[1] = 16'(8000);
`ifdef IFFT8_STAGE_SCALE_EN
        vecs[1].er[0] = 16'(1000);  vecs[1].ei[0] = 16'(0);
        vecs[1].er[1] = 16'(707);   vecs[1].ei[1] = 16'(707);
        vecs[1].er[2] = 16'(0);     vecs[1].ei[2] = 16'(1000);
        vecs[1].er[3] = 16'(-708);  vecs[1].ei[3] = 16'(707);
        vecs[1].er[4] = 16'(-1000); vecs[1].ei[4] = 16'(0);
        vecs[1].er[5] = 16'(-707);  vecs[1].ei[5] = 16'(-707);
        vecs[1].er[6] = 16'(0);     vecs[1].ei[6] = 16'(-1000);
        vecs[1].er[7] = 16'(707);   vecs[1].ei[7] = 16'(-707);
`else
        vecs[1].er[0] = 16'(8000);  vecs[1].ei[0] = 16'(0);
        vecs[1].er[1] = 16'(5656);  vecs[1].ei[1] = 16'(5656);
        vecs[1].er[2] = 16'(0);     vecs[1].ei[2] = 16'(8000);
        vecs[1].er[3] = 16'(-5657); vecs[1].ei[3] = 16'(5656);
        vecs[1].er[4] = 16'(-8000); vecs[1].ei[4] = 16'(0);
        vecs[1].er[5] = 16'(-5656); vecs[1].ei[5] = 16'(-5656);
        vecs[1].er[6] = 16'(0);     vecs[1].ei[6] = 16'(-8000);
        vecs[1].er[7] = 16'(5657);  vecs[1].ei[7] = 16'(-5656);
`endif
        // all bins at full scale: x0 pinned at max in both builds
        for (int k = 0; k < 8; k++) vecs[2].xr[k] = 16'(32767);
        vecs[2].er[0] = 16'(32767);
        // negative full-scale DC
        vecs[3].xr[0] = 16'(-32768);
        for (int n = 0; n < 8; n++) vecs[3].er[n] = 16'(-4096 * SC);
        // imaginary DC
        vecs[4].xi[0] = 16'(8000);
        for (int n = 0; n < 8; n++) vecs[4].ei[n] = 16'(1000 * SC);
        // tone k=2: x_n = j^n
        vecs[5].xr[2] = 16'(8000);
        for (int n = 0; n < 8; n++) begin
            case (n % 4)
                0: vecs[5].er[n] = 16'(1000 * SC);
                1: vecs[5].ei[n] = 16'(1000 * SC);
                2: vecs[5].er[n] = 16'(-1000 * SC);
                default: vecs[5].ei[n] = 16'(-1000 * SC);
            endcase
        end

        rst = 1'b1; start_i = 1'b0; X_R_i = '0; X_I_i = '0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_valid", 128'(valid_o), 128'(0));
        chk("rst_xr", x_R_o, '0);
        chk("rst_xi", x_I_o, '0);
        step();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // start while busy must be ignored
        nvalid  = 0;
        X_R_i   = vecs[0].xr;
        X_I_i   = vecs[0].xi;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 4) begin
                X_R_i = vecs[1].xr; X_I_i = vecs[1].xi; start_i = 1'b1;
            end else if (c == 5) begin
                start_i = 1'b0;
            end
            @(negedge clk);
            if (valid_o) nvalid++;
            if (c == 13) begin
                chk("rej_valid13", 128'(valid_o), 128'(1));
                chk("rej_xr", x_R_o, vecs[0].er);
                chk("rej_xi", x_I_o, vecs[0].ei);
            end
            step();
        end
        chk("rej_nvalid", 128'(nvalid), 128'(1));

        // continuous start: 14-cycle period
        X_R_i   = vecs[0].xr;
        X_I_i   = vecs[0].xi;
        start_i = 1'b1;
        for (int c = 0; c <= 45; c++) begin
            if (c == 41) start_i = 1'b0;
            @(negedge clk);
            if (c >= 1)
                chk($sformatf("b2b_valid_c%0d", c), 128'(valid_o),
                    128'(c == 13 || c == 27 || c == 41));
            if (c == 14 || c == 28) chk($sformatf("b2b_busy_c%0d", c), 128'(busy_o), 128'(0));
            if (c == 15 || c == 29) chk($sformatf("b2b_busy_c%0d", c), 128'(busy_o), 128'(1));
            if (valid_o) chk($sformatf("b2b_xr_c%0d", c), x_R_o, vecs[0].er);
            step();
        end

        // reset in the middle of a transform
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        X_R_i   = vecs[1].xr;
        X_I_i   = vecs[1].xi;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 5) rst = 1'b1;
            else if (c == 6) rst = 1'b0;
            @(negedge clk);
            chk($sformatf("abort_busy_c%0d", c), 128'(busy_o), 128'(c <= 5));
            chk($sformatf("abort_valid_c%0d", c), 128'(valid_o), 128'(0));
            step();
        end
        chk("abort_xr", x_R_o, '0);
        chk("abort_xi", x_I_o, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
